data_sram_responder: RTL and testbench

Data-side memory responder that serves the CPU's data port (data_en / data_wen / data_addr / data_wdata / data_rdata). It is a word-organised on-chip SRAM with byte-lane writes and a fixed, parameterised read latency. The read path is fully pipelined. After every reset the block runs a clear-on-reset initialisation sequence before it accepts requests. It sits between cpu_top and the simulation/FPGA top, and is the target end of the data interface.

---
 rtl/data_sram_responder.sv | 159 +++++++++++++++
 tb/tb_data_sram_responder.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_sram_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// data_sram_responder : word SRAM with byte-lane writes, pipelined fixed-latency
// reads and clear-on-reset init. Optional macro DSRAM_STATS_EN adds counters.
// Revision: 1.0
// ============================================================================
module data_sram_responder #(
   parameter int          ADDR_WIDTH   = 12,
   parameter int          READ_LATENCY = 1,
   parameter logic [31:0] BASE_ADDR    = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        data_en,
   input  logic [3:0]  data_wen,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic [31:0] data_rdata,
   output logic        data_valid,
   output logic        init_busy,
   output logic        addr_err
`ifdef DSRAM_STATS_EN
   ,
   output logic [31:0] rd_count,
   output logic [31:0] wr_count
`endif
);

   localparam int          c_depth = 1 << ADDR_WIDTH;
   localparam logic [32:0] c_span  = 33'(c_depth) << 2;

   typedef enum logic [0:0] {
      S_INIT  = 1'b0,
      S_READY = 1'b1
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [ADDR_WIDTH-1:0] r_init_cnt;
   logic                  w_clear_we;
   logic [31:0]           r_mem [c_depth];

   logic [31:0]           w_off;
   logic                  w_in_range;
   logic [ADDR_WIDTH-1:0] w_idx;
   logic                  w_accept;
   logic                  w_rd;
   logic                  w_wr;

   logic [31:0]             r_pipe_d [READ_LATENCY];
   logic [READ_LATENCY-1:0] r_pipe_v;
   logic                    r_addr_err;

   // Offset arithmetic wraps, so addresses below BASE_ADDR land out of range.
   assign w_off      = data_addr - BASE_ADDR;
   assign w_in_range = ({1'b0, w_off} < c_span);
   assign w_idx      = w_off[ADDR_WIDTH+1:2];
   assign w_accept   = data_en && (r_state == S_READY) && !rst;
   assign w_rd       = w_accept && (data_wen == 4'b0000);
   assign w_wr       = w_accept && (data_wen != 4'b0000) && w_in_range;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_INIT;
         r_init_cnt <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_clear_we) begin
            r_init_cnt <= r_init_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_clear_we  = 1'b0;
      init_busy   = 1'b0;
      case (r_state)
         S_INIT: begin
            init_busy  = 1'b1;
            w_clear_we = 1'b1;
            if (r_init_cnt == {ADDR_WIDTH{1'b1}}) begin
               w_state_nxt = S_READY;
            end
         end
         S_READY: begin
            w_state_nxt = S_READY;
         end
         default: begin
            w_state_nxt = S_INIT;
         end
      endcase
   end

   // Single write port shared between the init sweep and CPU byte writes.
   always_ff @(posedge clk) begin
      if (w_clear_we && !rst) begin
         r_mem[r_init_cnt] <= '0;
      end else if (w_wr) begin
         for (int b = 0; b < 4; b++) begin
            if (data_wen[b]) begin
               r_mem[w_idx][8*b +: 8] <= data_wdata[8*b +: 8];
            end
         end
      end
   end

   // Data stages only load behind a valid, so the last stage holds between responses.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pipe_v <= '0;
         for (int i = 0; i < READ_LATENCY; i++) begin
            r_pipe_d[i] <= '0;
         end
      end else begin
         r_pipe_v[0] <= w_rd;
         if (w_rd) begin
            r_pipe_d[0] <= w_in_range ? r_mem[w_idx] : 32'h0;
         end
         for (int i = 1; i < READ_LATENCY; i++) begin
            r_pipe_v[i] <= r_pipe_v[i-1];
            if (r_pipe_v[i-1]) begin
               r_pipe_d[i] <= r_pipe_d[i-1];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_addr_err <= 1'b0;
      end else begin
         r_addr_err <= w_accept && !w_in_range;
      end
   end

   assign data_valid = r_pipe_v[READ_LATENCY-1];
   assign data_rdata = r_pipe_d[READ_LATENCY-1];
   assign addr_err   = r_addr_err;

`ifdef DSRAM_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_count <= '0;
         wr_count <= '0;
      end else begin
         if (w_rd && w_in_range && (rd_count != 32'hFFFF_FFFF)) begin
            rd_count <= rd_count + 32'd1;
         end
         if (w_wr && (wr_count != 32'hFFFF_FFFF)) begin
            wr_count <= wr_count + 32'd1;
         end
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_data_sram_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_data_sram_responder : randomized scoreboard bench for data_sram_responder.
// Revision: 1.0
// ============================================================================
module tb_data_sram_responder;

   localparam int          AW    = 4;
   localparam int          RL    = 3;
   localparam int          DEPTH = 1 << AW;
   localparam logic [31:0] BASE  = 32'h0000_1000;

   logic        clk;
   logic        rst;
   logic        data_en;
   logic [3:0]  data_wen;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic [31:0] data_rdata;
   logic        data_valid;
   logic        init_busy;
   logic        addr_err;
`ifdef DSRAM_STATS_EN
   logic [31:0] rd_count;
   logic [31:0] wr_count;
`endif

   data_sram_responder #(
      .ADDR_WIDTH   (AW),
      .READ_LATENCY (RL),
      .BASE_ADDR    (BASE)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .data_en    (data_en),
      .data_wen   (data_wen),
      .data_addr  (data_addr),
      .data_wdata (data_wdata),
      .data_rdata (data_rdata),
      .data_valid (data_valid),
      .init_busy  (init_busy),
      .addr_err   (addr_err)
`ifdef DSRAM_STATS_EN
      ,
      .rd_count   (rd_count),
      .wr_count   (wr_count)
`endif
   );

   typedef struct {
      logic [31:0] data;
      int          due;
   } exp_t;

   exp_t        rq[$];
   int          eq[$];
   logic [31:0] model [DEPTH];
   logic [31:0] last_rd;
   int          cyc;
   int          ready_edge;
   int          total;
   int          bad;
   int          exp_rd;
   int          exp_wr;
   bit          mon_en;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
      end
   endtask

   // Scoreboard monitor: all output checking happens here, on the falling edge.
   exp_t e;
   logic exp_err;
   always @(negedge clk) begin
      if (mon_en) begin
         while (eq.size() > 0 && eq[0] < cyc) begin
            total++; bad++;
            $display("FAIL addr_err_stale cyc=%0d due=%0d", cyc, eq[0]);
            void'(eq.pop_front());
         end
         exp_err = (eq.size() > 0 && eq[0] == cyc);
         if (exp_err) void'(eq.pop_front());
         chk("addr_err", {31'd0, addr_err}, {31'd0, exp_err});

         if (data_valid === 1'b1) begin
            total++;
            if (rq.size() == 0) begin
               bad++;
               $display("FAIL unexpected_valid cyc=%0d got=%h exp=none", cyc, data_rdata);
            end else begin
               e = rq.pop_front();
               if (data_rdata !== e.data || e.due != cyc) begin
                  bad++;
                  $display("FAIL rdata cyc=%0d got=%h exp=%h due=%0d", cyc, data_rdata, e.data, e.due);
               end
               last_rd = e.data;
            end
         end else begin
            if (rq.size() > 0 && rq[0].due <= cyc) begin
               e = rq.pop_front();
               total++; bad++;
               $display("FAIL missing_valid cyc=%0d got=%b exp=1 due=%0d", cyc, data_valid, e.due);
            end
            chk("rdata_hold", data_rdata, last_rd);
         end
      end
   end

   // One request at a rising edge; the reference model is updated right after it.
   task automatic issue(input bit en, input logic [3:0] wen, input logic [31:0] addr,
                        input logic [31:0] wd);
      int          p;
      logic [31:0] off;
      logic [AW-1:0] idx;
      bit          inr;
      @(negedge clk);
      data_en    = en;
      data_wen   = wen;
      data_addr  = addr;
      data_wdata = wd;
      p = cyc + 1;
      @(posedge clk);
      #1;
      data_en = 1'b0;
      if (en && p >= ready_edge) begin
         off = addr - BASE;
         inr = (off < 32'(DEPTH * 4));
         idx = off[AW+1:2];
         if (wen == 4'b0000) begin
            rq.push_back('{data: (inr ? model[idx] : 32'h0), due: p + RL - 1});
            if (inr) exp_rd++;
         end else if (inr) begin
            for (int b = 0; b < 4; b++) begin
               if (wen[b]) model[idx][8*b +: 8] = wd[8*b +: 8];
            end
            exp_wr++;
         end
         if (!inr) eq.push_back(p);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rq.delete();
      eq.delete();
      last_rd = 32'h0;
      exp_rd  = 0;
      exp_wr  = 0;
      for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
      mon_en = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      ready_edge = cyc + 1 + DEPTH;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      total = 0; bad = 0; mon_en = 1'b0; ready_edge = 0;
      rst = 1'b1; data_en = 1'b0; data_wen = '0; data_addr = '0; data_wdata = '0;
      last_rd = '0; exp_rd = 0; exp_wr = 0;
      repeat (2) @(posedge clk);
      do_reset();

      // INIT: busy for DEPTH cycles while requests (some out of range) are ignored.
      for (int k = 0; k < DEPTH; k++) begin
         chk("init_busy_hi", {31'd0, init_busy}, 32'd1);
         data_en    = 1'b1;
         data_wen   = (k % 2 == 0) ? 4'hF : 4'h0;
         data_addr  = (k % 3 == 0) ? BASE - 32'd4 : BASE + 32'(4 * k);
         data_wdata = $urandom | 32'h1;
         @(posedge clk);
         @(negedge clk);
      end
      data_en = 1'b0;
      chk("init_busy_lo", {31'd0, init_busy}, 32'd0);
      for (int k = 0; k < DEPTH; k++) issue(1'b1, 4'h0, BASE + 32'(4 * k), 32'h0);

      // Byte-lane merge.
      issue(1'b1, 4'hF, BASE + 32'h8, 32'hAABB_CCDD);
      issue(1'b1, 4'b0101, BASE + 32'h8, 32'h1122_3344);
      issue(1'b1, 4'h0, BASE + 32'h8, 32'h0);

      // Back-to-back pipelined reads.
      for (int k = 0; k < 4; k++) issue(1'b1, 4'hF, BASE + 32'(4 * k), 32'(10 + k));
      for (int k = 0; k < 4; k++) issue(1'b1, 4'h0, BASE + 32'(4 * k), 32'h0);

      // Out-of-range write above and read below the window.
      issue(1'b1, 4'hF, BASE + 32'h40, 32'hDEAD_BEEF);
      issue(1'b1, 4'h0, BASE - 32'h4, 32'h0);
      issue(1'b1, 4'h0, BASE, 32'h0);

      // Randomized traffic, including idle cycles and ignored low address bits.
      for (int n = 0; n < 400; n++) begin
         int          r;
         logic [31:0] a;
         logic [3:0]  w;
         r = $urandom_range(0, 9);
         if (r == 0)      a = $urandom;
         else if (r == 1) a = BASE + 32'h40 + 32'(4 * $urandom_range(0, 15));
         else             a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(0, 3));
         w = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
         issue($urandom_range(0, 3) != 0, w, a, $urandom);
      end

      // Reset one edge after a read is accepted: that response must never appear.
      issue(1'b1, 4'hF, BASE + 32'h14, 32'h5A5A_A5A5);
      issue(1'b1, 4'h0, BASE + 32'h14, 32'h0);
      do_reset();
      chk("rst_init_busy", {31'd0, init_busy}, 32'd1);
      repeat (DEPTH) @(negedge clk);
      for (int k = 0; k < 8; k++) issue(1'b1, 4'h0, BASE + 32'(4 * k), 32'h0);

      // Short stats scenario after the re-init.
      for (int k = 0; k < 3; k++) issue(1'b1, 4'hF, BASE + 32'(4 * k), 32'(k + 1));
      issue(1'b1, 4'h0, BASE, 32'h0);
      issue(1'b1, 4'h0, BASE + 32'h4, 32'h0);
      issue(1'b1, 4'h0, BASE + 32'h80, 32'h0);

      repeat (RL + 2) @(negedge clk);
      chk("drain_reads", 32'(rq.size()), 32'd0);
      chk("drain_errs", 32'(eq.size()), 32'd0);
`ifdef DSRAM_STATS_EN
      chk("rd_count", rd_count, 32'(exp_rd));
      chk("wr_count", wr_count, 32'(exp_wr));
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
